neuron_scan_seq: RTL

//  Per-timestep neuron sweep sequencer for the neuromorphic core.
//  - Each dt_tick starts a sweep over a runtime-selected number of neurons.
//  - Issues one neuron address per cycle; ext_req stalls the issue.
//  - Carries addr/valid through programmable delay lines to the t_fix, update,

---
 rtl/neuron_pkg.sv | 10 +
 rtl/neuron_scan_seq_pipe_delay.sv | 40 ++++
 rtl/neuron_scan_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and helpers for the neuron sweep sequencer
package neuron_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} scan_state_t;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_scan_seq_pipe_delay.sv
// pipe_delay: fixed-depth {valid, addr} delay line whose addresses hold across bubbles
module pipe_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_addr,
    output logic         out_vld,
    output logic [W-1:0] out_addr,
    output logic         pend
);

    localparam logic [DEPTH-1:0] LOW = DEPTH'((1 << (DEPTH - 1)) - 1);

    logic [DEPTH-1:0]        vld;
    logic [DEPTH-1:0][W-1:0] addr;

    // valids shift every cycle; an address moves only behind a valid, so it holds while its stage is empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= '0;
            addr <= '0;
        end else begin
            vld[0] <= in_vld;
            if (in_vld) addr[0] <= in_addr;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) addr[k] <= addr[k-1];
            end
        end
    end

    assign out_vld  = vld[DEPTH-1];
    assign out_addr = addr[DEPTH-1];
    // data still inside the line that will be present next cycle
    assign pend     = |(vld & LOW);

endmodule

// File: rtl/neuron_scan_seq.sv
// neuron_scan_seq: per-timestep neuron sweep sequencer with staged address delay lines
module neuron_scan_seq
    import neuron_pkg::*;
#(
    parameter int NEURON_NO = 256,
    parameter int UPD_LAT   = 3,
    parameter int THR_LAT   = 1,
    parameter int SPK_LAT   = 2,
    parameter int REQ_W     = 2,
    parameter int AW        = addr_w(NEURON_NO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sys_en,
    input  logic [REQ_W-1:0] ext_req,
    input  logic             dt_tick,
    input  logic [AW:0]      active_no,
    output logic             t_fix_wr_en,
    output logic [AW-1:0]    t_fix_wr_addr,
    output logic             update_en,
    output logic [AW-1:0]    ampl_wr_addr,
    output logic [AW-1:0]    t_thr_rd_addr,
    output logic             sp_out_wr_en,
    output logic [AW-1:0]    sp_out_wr_addr,
    output logic             busy,
    output logic             sweep_done,
    output logic             overrun
);

    localparam logic [AW:0] NMAX = (AW+1)'(NEURON_NO);

    scan_state_t   state;
    logic [AW-1:0] scan_ptr;
    logic [AW-1:0] last;
    logic [AW-1:0] last_new;
    logic [AW:0]   cnt;
    logic          pending;
    logic          start_zero;
    logic          drained;
    logic          tick_mid;
    logic          u_pend;
    logic          r_vld;
    logic          r_pend;
    logic          s_pend;

    // sweep setup values and the "everything empty next cycle" condition that retires a sweep
    always_comb begin
        cnt        = (active_no > NMAX) ? NMAX : active_no;
        last_new   = AW'(cnt - 1'b1);
        start_zero = (active_no == '0);
        drained    = !(t_fix_wr_en | u_pend | update_en | r_pend | r_vld | s_pend);
        tick_mid   = dt_tick && sys_en && (state != IDLE);
    end

    // sweep FSM: start, issue one address per free cycle, drain, chain a queued tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            scan_ptr      <= '0;
            last          <= '0;
            pending       <= 1'b0;
            overrun       <= 1'b0;
            sweep_done    <= 1'b0;
            t_fix_wr_en   <= 1'b0;
            t_fix_wr_addr <= '0;
        end else begin
            sweep_done  <= 1'b0;
            t_fix_wr_en <= 1'b0;
            case (state)
                IDLE: if ((dt_tick && sys_en) || pending) begin
                    pending  <= 1'b0;
                    scan_ptr <= '0;
                    last     <= last_new;
                    state    <= start_zero ? DRAIN : SCAN;
                end
                SCAN: if (ext_req == '0) begin
                    t_fix_wr_en   <= 1'b1;
                    t_fix_wr_addr <= scan_ptr;
                    if (scan_ptr == last) state <= DRAIN;
                    else scan_ptr <= scan_ptr + 1'b1;
                end
                DRAIN: if (drained) begin
                    sweep_done <= 1'b1;
                    if (pending) begin
                        pending  <= 1'b0;
                        scan_ptr <= '0;
                        last     <= last_new;
                        state    <= start_zero ? DRAIN : SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (tick_mid) begin
                if (pending) overrun <= 1'b1;
                else pending <= 1'b1;
            end
        end
    end

    pipe_delay #(.W(AW), .DEPTH(UPD_LAT)) u_upd (
        .clk(clk), .reset(reset), .in_vld(t_fix_wr_en), .in_addr(t_fix_wr_addr),
        .out_vld(update_en), .out_addr(ampl_wr_addr), .pend(u_pend)
    );

    pipe_delay #(.W(AW), .DEPTH(THR_LAT)) u_thr (
        .clk(clk), .reset(reset), .in_vld(update_en), .in_addr(ampl_wr_addr),
        .out_vld(r_vld), .out_addr(t_thr_rd_addr), .pend(r_pend)
    );

    pipe_delay #(.W(AW), .DEPTH(SPK_LAT)) u_spk (
        .clk(clk), .reset(reset), .in_vld(update_en), .in_addr(ampl_wr_addr),
        .out_vld(sp_out_wr_en), .out_addr(sp_out_wr_addr), .pend(s_pend)
    );

    assign busy = (state != IDLE);

endmodule
